// File: rtl/ipsxe_floating_point_fx2fl_pack8_v1_0_pkg.sv
// rtl/ipsxe_floating_point_fx2fl_pack8_v1_0_pkg.sv - shared constants and float field type for the 8-bit fixed-to-float converter
//
// Purpose : single-precision field widths, exponent bias, pipeline latency
//           and the packed sign/exponent/fraction view of a float word.
// Ports   : none (package)
package ipsxe_floating_point_fx2fl_pack8_v1_0_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int LAT      = 4;

  localparam int MAG_W    = 8;
  localparam int LOC_W    = 3;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [FRAC_W-1:0] fraction;
  } float32_t;

endpackage

// File: rtl/ipsxe_floating_point_one_loc_sub8_v1_0.sv
// rtl/ipsxe_floating_point_one_loc_sub8_v1_0.sv - two-cycle leading-one locator for an 8-bit magnitude
//
// Purpose : returns the bit index of the most significant 1 and a zero flag,
//           both registered, two enabled cycles after i_data is presented.
// Ports   : i_clk, i_rst_n (async, active-low), i_aclken (stage enable),
//           i_data[7:0] magnitude in, one_location[2:0] index out,
//           zero_judge high when the magnitude was zero.
module ipsxe_floating_point_one_loc_sub8_v1_0
  import ipsxe_floating_point_fx2fl_pack8_v1_0_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_aclken,
  input  logic [MAG_W-1:0] i_data,
  output logic [LOC_W-1:0] one_location,
  output logic             zero_judge
);

  // First cycle picks the nibble holding the leading one; second cycle
  // resolves the position inside that nibble.
  logic       r_hi_nz;
  logic [3:0] r_nib;
  logic [1:0] w_nib_loc;
  logic       w_hi_nz;

  assign w_hi_nz = |i_data[7:4];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi_nz <= 1'b0;
      r_nib   <= 4'd0;
    end else if (i_aclken) begin
      r_hi_nz <= w_hi_nz;
      r_nib   <= w_hi_nz ? i_data[7:4] : i_data[3:0];
    end
  end

  always_comb begin
    w_nib_loc = 2'd0;
    if (r_nib[3])      w_nib_loc = 2'd3;
    else if (r_nib[2]) w_nib_loc = 2'd2;
    else if (r_nib[1]) w_nib_loc = 2'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      one_location <= '0;
      zero_judge   <= 1'b0;
    end else if (i_aclken) begin
      one_location <= {r_hi_nz, w_nib_loc};
      zero_judge   <= ~r_hi_nz & ~(|r_nib);
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_fx2fl_pack8_v1_0.sv
// rtl/ipsxe_floating_point_fx2fl_pack8_v1_0.sv - 4-stage exact 8-bit fixed-point to single-precision converter
//
// Purpose : S1 sign/magnitude, S2-S3 leading-one search (sub-module) with
//           delay-matched sign/magnitude, S4 float packing. One operand per
//           enabled cycle, no rounding needed since 8 bits fit the significand.
// Ports   : i_clk, i_rst_n (async, active-low), i_aclken (whole-pipeline enable),
//           i_valid / i_data[7:0] operand in,
//           o_valid / o_result[31:0] IEEE-754 single out, 4 enabled cycles later.
module ipsxe_floating_point_fx2fl_pack8_v1_0
  import ipsxe_floating_point_fx2fl_pack8_v1_0_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_aclken,
  input  logic             i_valid,
  input  logic [MAG_W-1:0] i_data,
  output logic             o_valid,
  output logic [31:0]      o_result
);

  // S1: sign and absolute value. Negation is done in 8 bits so -128
  // yields 0x80 read as unsigned rather than overflowing.
  logic             w_sign;
  logic [MAG_W-1:0] w_mag;
  logic             r_sign;
  logic [MAG_W-1:0] r_mag;

  assign w_sign = SIGNED_IN & i_data[MAG_W-1];
  assign w_mag  = w_sign ? MAG_W'(~i_data + 8'd1) : i_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sign <= 1'b0;
      r_mag  <= '0;
    end else if (i_aclken) begin
      r_sign <= w_sign;
      r_mag  <= w_mag;
    end
  end

  // S2-S3: leading-one location, plus matching two-register delay of
  // sign and magnitude so all four meet at the S4 input.
  logic [LOC_W-1:0] w_loc;
  logic             w_zero;
  logic             r_sign_d1, r_sign_d2;
  logic [MAG_W-1:0] r_mag_d1,  r_mag_d2;

  ipsxe_floating_point_one_loc_sub8_v1_0 u_one_loc (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_aclken     (i_aclken),
    .i_data       (r_mag),
    .one_location (w_loc),
    .zero_judge   (w_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sign_d1 <= 1'b0;
      r_sign_d2 <= 1'b0;
      r_mag_d1  <= '0;
      r_mag_d2  <= '0;
    end else if (i_aclken) begin
      r_sign_d1 <= r_sign;
      r_sign_d2 <= r_sign_d1;
      r_mag_d1  <= r_mag;
      r_mag_d2  <= r_mag_d1;
    end
  end

  // S4: normalise so the leading one lands on bit 7 (the hidden bit);
  // bits 6:0 become the top of the fraction.
  logic [MAG_W-1:0] w_norm;
  float32_t         w_pack;
  logic [31:0]      r_result;

  assign w_norm = r_mag_d2 << (3'd7 - w_loc);

  always_comb begin
    w_pack = '0;
    if (!w_zero) begin
      w_pack.sign     = r_sign_d2;
      w_pack.exponent = EXP_W'(EXP_BIAS) + {5'd0, w_loc};
      w_pack.fraction = {w_norm[6:0], 16'd0};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
    end else if (i_aclken) begin
      r_result <= w_pack;
    end
  end

  // Valid pipeline runs alongside the data path; o_result updates every
  // enabled cycle and only o_valid marks meaningful words.
  logic [LAT-1:0] r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_aclken) begin
      r_valid <= {r_valid[LAT-2:0], i_valid};
    end
  end

  assign o_valid  = r_valid[LAT-1];
  assign o_result = r_result;

endmodule

// File: tb/tb_ipsxe_floating_point_fx2fl_pack8_v1_0.sv
// tb/tb_ipsxe_floating_point_fx2fl_pack8_v1_0.sv - self-checking bench for the 8-bit fixed-to-float converter
module tb_ipsxe_floating_point_fx2fl_pack8_v1_0;

  logic        clk;
  logic        rst_n;
  logic        aclken;
  logic        valid;
  logic [7:0]  data;
  logic        o_valid_s, o_valid_u;
  logic [31:0] o_result_s, o_result_u;

  int errs   = 0;
  int checks = 0;

  ipsxe_floating_point_fx2fl_pack8_v1_0 #(.SIGNED_IN(1'b1)) dut_s (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_aclken (aclken),
    .i_valid  (valid),
    .i_data   (data),
    .o_valid  (o_valid_s),
    .o_result (o_result_s)
  );

  ipsxe_floating_point_fx2fl_pack8_v1_0 #(.SIGNED_IN(1'b0)) dut_u (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_aclken (aclken),
    .i_valid  (valid),
    .i_data   (data),
    .o_valid  (o_valid_u),
    .o_result (o_result_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: integer value -> real -> double bits -> single fields.
  function automatic logic [31:0] ref_float(input logic [7:0] d, input bit sgn);
    int          v;
    real         r;
    logic [63:0] b;
    logic [10:0] e;
    v = sgn ? int'($signed(d)) : int'(d);
    if (v == 0) return 32'h0;
    r = v;
    b = $realtobits(r);
    e = b[62:52];
    return {b[63], 8'(e - 11'd896), b[51:29]};
  endfunction

  // Model: history of operands sampled on enabled edges since reset; the
  // output after an edge reflects the operand sampled three enabled edges
  // earlier (fourth enabled edge counting the sampling one).
  typedef struct {
    bit       v;
    bit [7:0] d;
  } ent_t;
  ent_t hist[$];
  int   filled = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      filled = 0;
    end else if (aclken) begin
      hist.push_back('{v: valid, d: data});
      if (hist.size() > 4) void'(hist.pop_front());
      if (filled < 4) filled++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid_s", 32'(o_valid_s), 32'h0);
      chk("rst_result_s", o_result_s, 32'h0);
      chk("rst_valid_u", 32'(o_valid_u), 32'h0);
      chk("rst_result_u", o_result_u, 32'h0);
    end else if (filled >= 4) begin
      chk("model_valid_s", 32'(o_valid_s), 32'(hist[0].v));
      chk("model_valid_u", 32'(o_valid_u), 32'(hist[0].v));
      chk("model_result_s", o_result_s, ref_float(hist[0].d, 1'b1));
      chk("model_result_u", o_result_u, ref_float(hist[0].d, 1'b0));
    end else begin
      chk("fill_valid_s", 32'(o_valid_s), 32'h0);
      chk("fill_valid_u", 32'(o_valid_u), 32'h0);
    end
  end

  // Back-to-back literal sequence with hand-computed results.
  task automatic run_seq(input string nm, input logic [7:0] din[6],
                         input logic [31:0] lit[6], input int n, input bit use_u);
    for (int c = 0; c < n + 4; c++) begin
      @(negedge clk);
      #1;
      if (c >= 4) begin
        chk({nm, "_valid"}, 32'(use_u ? o_valid_u : o_valid_s), 32'h1);
        chk({nm, "_result"}, use_u ? o_result_u : o_result_s, lit[c-4]);
      end
      if (c < n) begin
        valid = 1'b1;
        data  = din[c];
      end else begin
        valid = 1'b0;
        data  = 8'h00;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      valid  = 1'b0;
      aclken = 1'b1;
    end
  endtask

  logic [7:0]  din_a[6];
  logic [31:0] lit_a[6];
  logic [7:0]  din_b[6];
  logic [31:0] lit_b[6];

  initial begin
    rst_n  = 1'b0;
    aclken = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Signed literal sequence: 1, -1, 5, 127, -128, 0
    din_a = '{8'h01, 8'hFF, 8'h05, 8'h7F, 8'h80, 8'h00};
    lit_a = '{32'h3F800000, 32'hBF800000, 32'h40A00000,
              32'h42FE0000, 32'hC3000000, 32'h00000000};
    run_seq("lit_signed", din_a, lit_a, 6, 1'b0);
    idle(4);

    // Unsigned literal sequence: 0xFF, 0x80, 0x01
    din_b = '{8'hFF, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00};
    lit_b = '{32'h437F0000, 32'h43000000, 32'h3F800000,
              32'h0, 32'h0, 32'h0};
    run_seq("lit_unsigned", din_b, lit_b, 3, 1'b1);
    idle(6);

    // Clock-enable stall: 0x05 sampled, two enabled edges, three disabled,
    // result expected after the 4th enabled edge (7th raw edge).
    @(negedge clk); #1; valid = 1'b1; data = 8'h05;
    @(negedge clk); #1; valid = 1'b0; data = 8'h00;
    @(negedge clk); #1; aclken = 1'b0;
    @(negedge clk); #1;
    chk("stall_hold_valid", 32'(o_valid_s), 32'h0);
    @(negedge clk); #1;
    @(negedge clk); #1; aclken = 1'b1;
    @(negedge clk); #1;
    chk("stall_early_valid", 32'(o_valid_s), 32'h0);
    @(negedge clk); #1;
    chk("stall_valid", 32'(o_valid_s), 32'h1);
    chk("stall_result", o_result_s, 32'h40A00000);
    idle(6);

    // Valid pattern 1,0,1,1,0
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      valid = (i == 0 || i == 2 || i == 3);
      data  = 8'(i + 3);
    end
    idle(6);

    // Reset with three operands in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      valid = 1'b1;
      data  = 8'(8'h11 * (i + 1));
    end
    @(negedge clk); #1;
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid_s", 32'(o_valid_s), 32'h0);
    chk("midrst_result_s", o_result_s, 32'h0);
    chk("midrst_valid_u", 32'(o_valid_u), 32'h0);
    chk("midrst_result_u", o_result_u, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(8);

    // Exhaustive sweep of every input code, back to back
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); #1;
      valid = 1'b1;
      data  = 8'(i);
    end
    idle(6);

    // Randomised valid/data/enable traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      valid  = 1'($urandom_range(0, 1));
      data   = 8'($urandom);
      aclken = ($urandom_range(0, 4) != 0);
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ipsxe_floating_point_fx2fl_pack8_v1_0.md
IPSXE_FLOATING_POINT_FX2FL_PACK8_V1_0 -- requirements
Module: ipsxe_floating_point_fx2fl_pack8_v1_0

Interface
REQ-001 Parameter SIGNED_IN, default 1, meaning: 1 = i_data is two's-complement signed; 0 = i_data is unsigned.
REQ-002 i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_aclken  input  1  pipeline clock enable; when low, every register holds its value.
REQ-005 i_valid  input  1  i_data is qualified this cycle.
REQ-006 i_data  input  8  fixed-point integer operand.
REQ-007 o_valid  output  1  o_result is qualified this cycle.
REQ-008 o_result  output  32  IEEE-754 single-precision equivalent of the operand.

Function
REQ-009 Conversion SHALL be exact; no rounding; 8 magnitude bits always fit in the 24-bit significand.
REQ-010 Stage S1 SHALL register:
  - sign = i_data[7] when SIGNED_IN=1, else 0;
  - mag = two's-complement absolute value (8-bit unsigned) when sign=1, else i_data.
REQ-011 Magnitude of -128 (0x80, SIGNED_IN=1) SHALL be 0x80 unsigned, not overflow.
REQ-012 Stages S2-S3 SHALL produce loc[2:0] (bit index of most significant 1 in mag) and zero flag (mag==0), two registered cycles after S1.
REQ-013 mag and sign SHALL be delay-matched by two registers so they align with loc/zero at S3.
REQ-014 Stage S4 SHALL register o_result:
  - sign = bit 31;
  - exponent [30:23] = 127 + loc;
  - fraction [22:16] = bits [6:0] of (mag << (7 - loc));
  - fraction [15:0] = 0.
REQ-015 When zero=1, o_result SHALL be 0x00000000 (positive zero) regardless of sign.
REQ-016 Latency SHALL be exactly 4 enabled cycles (i_aclken-high rising edges) from i_valid/i_data sample to o_valid/o_result.
REQ-017 Throughput SHALL be one operand per enabled cycle; no backpressure; no stall other than i_aclken.
REQ-018 i_valid SHALL propagate through a 4-deep valid shift register gated by i_aclken.
REQ-019 o_result SHALL update every enabled cycle, regardless of valid; only o_valid qualifies it.
REQ-020 With i_aclken low, o_valid and o_result SHALL hold. In-flight operands SHALL resume unchanged when i_aclken returns high.

Reset
REQ-021 Reset assertion SHALL asynchronously clear every pipeline register to zero: o_valid=0, o_result=0x00000000.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight operands; no o_valid pulse SHALL appear for them after release.
REQ-023 The first operand after reset release SHALL emerge after exactly 4 enabled cycles.

Structure
REQ-024 A shared package SHALL hold:
  - the constants EXP_BIAS=127, EXP_W=8, FRAC_W=23, LAT=4;
  - the float field-packing typedef (sign/exponent/fraction).
REQ-025 The leading-one detection (S2-S3) SHALL be a single instantiated sub-module, ipsxe_floating_point_one_loc_sub8_v1_0, with 2-cycle latency and registered outputs one_location[2:0] and zero_judge.
REQ-026 S1, the delay-match registers, S4 packing and the valid pipeline SHALL reside in this module.

Verification
REQ-027 SIGNED_IN=1, i_aclken=1, back-to-back valid inputs 1, -1, 5, 127, -128, 0 -> four cycles later, consecutive outputs 0x3F800000, 0xBF800000, 0x40A00000, 0x42FE0000, 0xC3000000, 0x00000000, with o_valid high for six cycles.
REQ-028 SIGNED_IN=0, inputs 0xFF, 0x80, 0x01 -> outputs 0x437F0000, 0x43000000, 0x3F800000.
REQ-029 Input 0x05 valid, then i_aclken low for 3 cycles after the second enabled edge -> o_result 0x40A00000 with o_valid appears on the 4th enabled edge (7 raw cycles); outputs frozen while disabled.
REQ-030 Valid pattern 1,0,1,1,0 -> o_valid pattern 1,0,1,1,0 delayed by exactly 4 cycles.
REQ-031 i_rst_n pulsed low while 3 operands are in flight -> o_valid=0 and o_result=0 immediately; no stale o_valid afterwards.
REQ-032 Exhaustive sweep of all 256 i_data values, both SIGNED_IN settings -> every o_result bit-exact against a reference real-to-float model.
